intdiv_iter: RTL and testbench
==============================

Name: intdiv_iter

Overview:
Iterative radix-2^k integer divider for RISC-V DIV/DIVU/REM/REMU. It is the parametrised successor to the fixed single-width divider path. Width and bits-per-cycle are generic, taken from the cvw_t fields XLEN and IDIV_BITSPERCYCLE. It sits beside the FPU divide path and is selected when IDIV_ON_FPU=0, with a valid/ready handshake on both sides and a flush input.

Parameters:
XLEN, 64, operand/result width; legal values 32 or 64.
BITSPERCYCLE, 1, quotient bits retired per iteration; legal values 1, 2, 4; must divide XLEN.
NITER, XLEN/BITSPERCYCLE, derived iteration count; not overridable.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset; asynchronous, active-low.
flush_i  in  1  abort the current operation; result discarded.
in_valid_i  in  1  operands valid.
in_ready_o  out  1  divider can accept a new operation.
a_i  in  XLEN  dividend.
b_i  in  XLEN  divisor.
signed_i  in  1  1 = DIV/REM, 0 = DIVU/REMU.
rem_i  in  1  1 = return remainder, 0 = return quotient.
out_valid_o  out  1  result valid.
out_ready_i  in  1  consumer accepts the result.
result_o  out  XLEN  quotient or remainder.

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE; in_ready_o=1; out_valid_o=0; result_o=0; all internal registers cleared.
- States: IDLE, PREP, ITER, DONE.
- IDLE: in_ready_o=1. An operation is accepted on a clock edge with in_valid_i & in_ready_o; operands and mode bits are latched; next state PREP.
- PREP (1 cycle):
  - Take magnitudes when signed_i.
  - Record quotient sign = sa^sb and remainder sign = sa.
  - Detect special cases. If any applies, go to DONE; otherwise clear the iteration counter and go to ITER.
- ITER (exactly NITER cycles):
  - Per cycle, BITSPERCYCLE chained restoring-subtract steps on the {rem, quotient} shift pair.
  - Counter width is clog2(NITER).
  - Exit to DONE when the counter reaches NITER-1.
- DONE:
  - out_valid_o=1; result_o is sign-corrected (two's-complement negate if the recorded sign is 1 and signed_i).
  - Hold result_o stable while out_ready_i=0.
  - On out_valid_o & out_ready_i, go to IDLE.
  - in_ready_o=0 in all states except IDLE; no same-cycle accept in DONE.
- Latency, counted from the accepting edge:
  - out_valid_o rises NITER+2 edges later in the normal case.
  - out_valid_o rises 2 edges later for special cases.
- Special cases, resolved in PREP:
  - Divide by zero (b=0): quotient = all ones; remainder = a (unmodified, signed or unsigned).
  - Signed overflow (a = most-negative value, b = -1, signed_i=1): quotient = a; remainder = 0.
- Sign rules: the quotient truncates toward zero; the remainder takes the dividend's sign; |rem| < |b|.
- Flush:
  - flush_i=1 in PREP, ITER or DONE forces IDLE on the next edge; out_valid_o=0 from that edge on; no result is emitted.
  - flush_i has priority over out_ready_i, and over in_valid_i in the same cycle: no accept while flush_i=1.
- Reset mid-operation: immediate asynchronous return to IDLE with reset values; no partial result is visible.
- Assertions (simulation only): BITSPERCYCLE in {1,2,4}; XLEN in {32,64}; a_i/b_i stable-free (latched), so no input-stability requirement after accept.

Optional Feature:
INTDIV_WORDOP_EN:
- When defined:
  - Adds port word_i (in, 1), valid only with XLEN=64, implementing DIVW/DIVUW/REMW/REMUW.
  - The operation uses a_i[31:0] and b_i[31:0], sign- or zero-extended per signed_i.
  - ITER runs 32/BITSPERCYCLE cycles.
  - Special cases are evaluated at 32 bits (overflow = 0x8000_0000 / -1).
  - result_o = the 32-bit result sign-extended to 64 bits, regardless of signed_i (RISC-V *W semantics).
- When undefined: no word_i port; all operations are full XLEN.

Test Plan:
- XLEN=64, BPC=1, DIVU 100/7 -> result_o=14, out_valid_o exactly 66 edges after accept; repeat with rem_i=1 -> 2.
- BPC=4, signed DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD (-3), out_valid_o 18 edges after accept; REM -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVU 5/0 -> 0xFFFF_FFFF_FFFF_FFFF and REMU 5/0 -> 5, each with out_valid_o 2 edges after accept.
- Signed 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> DIV 0x8000_0000_0000_0000, REM 0.
- Backpressure, then flush:
  - Hold out_ready_i=0 for 5 cycles in DONE -> result_o stable, in_ready_o=0; out_ready_i=1 -> IDLE next edge.
  - Assert flush_i in ITER cycle 10 -> IDLE next edge, no out_valid_o; a new 9/3 then yields 3.
- rst_ni low mid-ITER -> out_valid_o=0 and in_ready_o=1 immediately; with INTDIV_WORDOP_EN, DIVW 0x8000_0000/-1 -> 0xFFFF_FFFF_8000_0000.

Source files
------------

// File: rtl/intdiv_iter.sv
// Iterative radix-2^k integer divider for DIV/DIVU/REM/REMU with valid/ready on both sides and flush.
// Optional INTDIV_WORDOP_EN adds word_i for the 32-bit *W operations (XLEN=64 only).
module intdiv_iter #(
  parameter int XLEN         = 64,
  parameter int BITSPERCYCLE = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            signed_i,
  input  logic            rem_i,
`ifdef INTDIV_WORDOP_EN
  input  logic            word_i,
`endif
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o
);
  localparam int NITER = XLEN / BITSPERCYCLE;
  localparam int CW    = $clog2(NITER);
  localparam logic [CW-1:0] LAST = CW'(NITER - 1);

  typedef enum logic [1:0] {IDLE, PREP, ITER, DONE} state_t;
  state_t state_q, state_d;

  logic [XLEN-1:0] a_q, b_q, quo_q, res_q;
  logic [XLEN:0]   rem_q;
  logic [CW-1:0]   cnt_q;
  logic            sgn_q, remsel_q, qneg_q, rneg_q, vld_q, word_q;

  logic            sa, sb, div0, ovf, special, last;
  logic [XLEN-1:0] amag, bmag, min_val, a_in, b_in, fin;
  logic [XLEN:0]   r;
  logic [XLEN-1:0] q;
  logic            accept;

  assign accept = in_valid_i & in_ready_o & ~flush_i;

`ifdef INTDIV_WORDOP_EN
  // *W ops are handled as 64-bit ops on extended operands; only the iteration count and the final sign-extension differ.
  assign a_in    = word_i ? (signed_i ? {{(XLEN-32){a_i[31]}}, a_i[31:0]} : {{(XLEN-32){1'b0}}, a_i[31:0]}) : a_i;
  assign b_in    = word_i ? (signed_i ? {{(XLEN-32){b_i[31]}}, b_i[31:0]} : {{(XLEN-32){1'b0}}, b_i[31:0]}) : b_i;
  assign min_val = word_q ? ~XLEN'(32'h7FFF_FFFF) : {1'b1, {(XLEN-1){1'b0}}};
  assign last    = word_q ? (cnt_q == CW'(32 / BITSPERCYCLE - 1)) : (cnt_q == LAST);
`else
  assign a_in    = a_i;
  assign b_in    = b_i;
  assign min_val = {1'b1, {(XLEN-1){1'b0}}};
  assign last    = (cnt_q == LAST);
  assign word_q  = 1'b0;
`endif

  assign sa      = sgn_q & a_q[XLEN-1];
  assign sb      = sgn_q & b_q[XLEN-1];
  assign amag    = sa ? -a_q : a_q;
  assign bmag    = sb ? -b_q : b_q;
  assign div0    = (b_q == '0);
  assign ovf     = sgn_q & (a_q == min_val) & (b_q == '1);
  assign special = div0 | ovf;

  // BITSPERCYCLE chained restoring steps; r stays below b so its MSB is always zero before the shift.
  always_comb begin
    r = rem_q;
    q = quo_q;
    for (int i = 0; i < BITSPERCYCLE; i++) begin
      r = {r[XLEN-1:0], q[XLEN-1]};
      q = {q[XLEN-2:0], 1'b0};
      if (r >= {1'b0, b_q}) begin
        r    = r - {1'b0, b_q};
        q[0] = 1'b1;
      end
    end
  end

  always_comb begin
    fin = remsel_q ? rem_q[XLEN-1:0] : quo_q;
    if (remsel_q ? rneg_q : qneg_q) fin = -fin;
`ifdef INTDIV_WORDOP_EN
    if (word_q) fin = {{(XLEN-32){fin[31]}}, fin[31:0]};
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready_o = (state_q == IDLE);
    case (state_q)
      IDLE: if (accept)                state_d = PREP;
      PREP: state_d = special ? DONE : ITER;
      ITER: if (last)                  state_d = DONE;
      DONE: if (vld_q && out_ready_i)  state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q <= '0; b_q <= '0; quo_q <= '0; rem_q <= '0; res_q <= '0; cnt_q <= '0;
      sgn_q <= 1'b0; remsel_q <= 1'b0; qneg_q <= 1'b0; rneg_q <= 1'b0; vld_q <= 1'b0;
    end else if (flush_i) begin
      vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          a_q <= a_in; b_q <= b_in; sgn_q <= signed_i; remsel_q <= rem_i;
        end
        PREP: begin
          // Special results are preloaded as already-signed values so DONE needs no extra case.
          cnt_q  <= '0;
          qneg_q <= 1'b0;
          rneg_q <= 1'b0;
          if (div0) begin
            quo_q <= '1;  rem_q <= {1'b0, a_q};
          end else if (ovf) begin
            quo_q <= a_q; rem_q <= '0;
          end else begin
            quo_q  <= word_q ? (amag << 32) : amag;
            rem_q  <= '0;
            b_q    <= bmag;
            qneg_q <= sa ^ sb;
            rneg_q <= sa;
          end
        end
        ITER: begin
          quo_q <= q;
          rem_q <= r;
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: begin
          if (!vld_q) begin
            res_q <= fin;
            vld_q <= 1'b1;
          end else if (out_ready_i) begin
            vld_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef INTDIV_WORDOP_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                          word_q <= 1'b0;
    else if (!flush_i && state_q == IDLE && accept) word_q <= word_i;
  end
`endif

  assign out_valid_o = vld_q;
  assign result_o    = res_q;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    assert (BITSPERCYCLE == 1 || BITSPERCYCLE == 2 || BITSPERCYCLE == 4)
      else $error("intdiv_iter: BITSPERCYCLE must be 1, 2 or 4");
    assert (XLEN == 32 || XLEN == 64)
      else $error("intdiv_iter: XLEN must be 32 or 64");
`ifdef INTDIV_WORDOP_EN
    assert (XLEN == 64) else $error("intdiv_iter: word ops need XLEN=64");
`endif
  end
`endif
endmodule

// File: tb/tb_intdiv_iter.sv
// Scoreboard bench: two dividers (BPC=1 and BPC=4, XLEN=64) fed directed vectors; a negedge monitor checks results and latency.
module tb_intdiv_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush[2], in_valid[2], in_ready[2], sgn[2], remf[2], out_valid[2], out_ready[2];
  logic [63:0] a[2], b[2], res[2];
  logic        word[2];

  intdiv_iter #(.XLEN(64), .BITSPERCYCLE(1)) u_bpc1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .a_i(a[0]), .b_i(b[0]), .signed_i(sgn[0]), .rem_i(remf[0]),
`ifdef INTDIV_WORDOP_EN
    .word_i(word[0]),
`endif
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .result_o(res[0]));

  intdiv_iter #(.XLEN(64), .BITSPERCYCLE(4)) u_bpc4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .a_i(a[1]), .b_i(b[1]), .signed_i(sgn[1]), .rem_i(remf[1]),
`ifdef INTDIV_WORDOP_EN
    .word_i(word[1]),
`endif
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .result_o(res[1]));

  typedef struct { logic [63:0] res; int lat; } exp_t;
  exp_t q0[$], q1[$];
  int n_cmp = 0, n_bad = 0;
  int ncnt[2], acc_at[2], seen[2];
  logic pv[2];
  logic [63:0] held[2];

  task automatic check(string name, logic [63:0] act, logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic mon(int d);
    exp_t e;
    bit   have;
    ncnt[d]++;
    if (rst_n && in_valid[d] && in_ready[d] && !flush[d]) acc_at[d] = ncnt[d] + 1;
    if (out_valid[d] && !pv[d]) begin
      have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
      if (!have) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_output dut%0d: got %h expected no output", d, res[d]);
      end else begin
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
        check($sformatf("result dut%0d", d), res[d], e.res);
        check($sformatf("latency dut%0d", d), 64'(ncnt[d] - acc_at[d]), 64'(e.lat));
        seen[d]++;
      end
      held[d] = res[d];
    end else if (out_valid[d]) begin
      check($sformatf("hold dut%0d", d), res[d], held[d]);
    end
    pv[d] = out_valid[d];
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Called at posedge+#1; leaves the caller at posedge+#1 just after the accepting edge.
  task automatic issue(int d, logic [63:0] av, logic [63:0] bv, logic s, logic r, logic w,
                       bit push, logic [63:0] er, int el);
    exp_t e;
    int   t = 0;
    while (!in_ready[d] && t < 300) begin @(posedge clk); #1; t++; end
    if (!in_ready[d]) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout dut%0d: got in_ready=0 expected 1", d);
    end
    if (push) begin
      e.res = er; e.lat = el;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    a[d] = av; b[d] = bv; sgn[d] = s; remf[d] = r; word[d] = w; in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic run(int d, logic [63:0] av, logic [63:0] bv, logic s, logic r, logic w,
                     logic [63:0] er, int el);
    int tgt = seen[d] + 1;
    int t   = 0;
    issue(d, av, bv, s, r, w, 1'b1, er, el);
    while (!(seen[d] >= tgt && in_ready[d]) && t < 300) begin @(posedge clk); #1; t++; end
    if (t >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout dut%0d: got no result expected %h", d, er);
    end
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      flush[i] = 0; in_valid[i] = 0; sgn[i] = 0; remf[i] = 0; word[i] = 0;
      out_ready[i] = 1; a[i] = '0; b[i] = '0;
      ncnt[i] = 0; acc_at[i] = 0; seen[i] = 0; pv[i] = 0; held[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_in_ready", 64'(in_ready[i]), 64'd1);
      check("reset_out_valid", 64'(out_valid[i]), 64'd0);
      check("reset_result", res[i], 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // BPC=1: NITER=64, normal latency 66
    run(0, 64'd100, 64'd7, 0, 0, 0, 64'd14, 66);
    run(0, 64'd100, 64'd7, 0, 1, 0, 64'd2, 66);
    run(0, 64'd5, 64'd0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    run(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0, 1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 66);

    // BPC=4: NITER=16, normal latency 18
    run(1, -64'sd7, 64'd2, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 18);
    run(1, -64'sd7, 64'd2, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 18);
    run(1, 64'd7, -64'sd2, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 18);
    run(1, 64'd7, -64'sd2, 1, 1, 0, 64'd1, 18);
    run(1, -64'sd7, -64'sd2, 1, 0, 0, 64'd3, 18);
    run(1, 64'd5, 64'd0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    run(1, 64'd5, 64'd0, 0, 1, 0, 64'd5, 2);
    run(1, -64'sd5, 64'd0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFB, 2);
    run(1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 64'h8000_0000_0000_0000, 2);
    run(1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 64'd0, 2);
    run(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 18);
    run(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, 1, 0, 64'd1, 18);

    // Backpressure in DONE for 5 cycles
    out_ready[1] = 1'b0;
    issue(1, 64'd100, 64'd7, 0, 0, 0, 1'b1, 64'd14, 18);
    t = 0;
    while (!out_valid[1] && t < 100) begin @(posedge clk); #1; t++; end
    check("bp_valid", 64'(out_valid[1]), 64'd1);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_in_ready", 64'(in_ready[1]), 64'd0);
      check("bp_out_valid", 64'(out_valid[1]), 64'd1);
    end
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 64'(out_valid[1]), 64'd0);
    check("bp_release_ready", 64'(in_ready[1]), 64'd1);

    // Flush in ITER cycle 10 (ITER cycle k sits between accept+k+1 and accept+k+2)
    issue(0, 64'd100, 64'd7, 0, 0, 0, 1'b0, 64'd0, 0);
    repeat (11) @(posedge clk);
    #1 flush[0] = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0;
    check("flush_in_ready", 64'(in_ready[0]), 64'd1);
    check("flush_out_valid", 64'(out_valid[0]), 64'd0);
    repeat (70) @(posedge clk);
    #1;
    check("flush_no_result", 64'(out_valid[0]), 64'd0);
    run(0, 64'd9, 64'd3, 0, 0, 0, 64'd3, 66);

`ifdef INTDIV_WORDOP_EN
    run(1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 0, 1, 64'hFFFF_FFFF_8000_0000, 2);
    run(1, 64'h0000_0001_0000_0064, 64'd7, 0, 0, 1, 64'd14, 10);
    run(1, 64'h0000_0000_FFFF_FFF9, 64'd2, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 10);
    run(1, 64'h0000_0000_FFFF_FFFF, 64'd1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 10);
`endif

    // Asynchronous reset mid-ITER
    issue(1, 64'd100, 64'd7, 0, 0, 0, 1'b0, 64'd0, 0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid[1]), 64'd0);
    check("midreset_in_ready", 64'(in_ready[1]), 64'd1);
    check("midreset_result", res[1], 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("postreset_no_result", 64'(out_valid[1]), 64'd0);
    check("queue0_empty", 64'(q0.size()), 64'd0);
    check("queue1_empty", 64'(q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
